memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 27 ++
 rtl/memory_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - memory bus carrying requests to and responses from a memory slave
interface MemoryBus #(
  parameter int MASTER_ID_WIDTH = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 24
);
  logic [MASTER_ID_WIDTH-1:0] msID;
  logic [ADDRESS_WIDTH-1:0]   msAddress;
  logic [DATA_WIDTH-1:0]      msData;
  logic                       msWrite;
  logic                       msValid;
  logic                       msTaken;
  logic [MASTER_ID_WIDTH-1:0] smID;
  logic [DATA_WIDTH-1:0]      smData;
  logic                       smValid;
  logic                       smTaken;

  modport Slave (
    input  msID, msAddress, msData, msWrite, msValid, smTaken,
    output msTaken, smID, smData, smValid
  );

  modport Master (
    output msID, msAddress, msData, msWrite, msValid, smTaken,
    input  msTaken, smID, smData, smValid
  );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word memory slave with credit-controlled in-order read response buffer
module memory_responder #(
  parameter int MASTER_ID_WIDTH = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 24,
  parameter int DEPTH           = 1024,
  parameter int RESP_DEPTH      = 4
) (
  input logic clk,
  input logic rst_n,
  MemoryBus.Slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(RESP_DEPTH);

  logic [IW-1:0]              index;
  logic                       write_accept;
  logic                       read_accept;
  logic                       push;
  logic                       pop;
  logic [CW-1:0]              credits;
  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;

  logic [DATA_WIDTH-1:0]      storage [DEPTH];

  // RAM read stage: one read in flight between accept and buffer entry
  logic                       rd_valid;
  logic [MASTER_ID_WIDTH-1:0] rd_id;
  logic [DATA_WIDTH-1:0]      rd_data;

  logic [MASTER_ID_WIDTH-1:0] buf_id   [RESP_DEPTH];
  logic [DATA_WIDTH-1:0]      buf_data [RESP_DEPTH];

  // Upper address bits alias onto the same word; they are deliberately dropped
  if (ADDRESS_WIDTH > IW) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.msAddress[ADDRESS_WIDTH-1:IW];
  end

  assign index = bus.msAddress[IW-1:0];

  // Writes always go through; reads need a credit so a response slot is reserved
  assign bus.msTaken  = rst_n && bus.msValid && (bus.msWrite || (credits != '0));
  assign write_accept = bus.msTaken && bus.msWrite;
  assign read_accept  = bus.msTaken && !bus.msWrite;

  assign push = rd_valid;
  assign pop  = bus.smValid && bus.smTaken;

  assign bus.smValid = (count != '0);
  assign bus.smID    = buf_id[rd_ptr];
  assign bus.smData  = buf_data[rd_ptr];

  // Storage array and its synchronous read port; contents survive reset
  always_ff @(posedge clk) begin
    if (write_accept) begin
      storage[index] <= bus.msData;
    end
    if (read_accept) begin
      rd_data <= storage[index];
    end
  end

  // Read-stage valid flag and requester ID travelling with the RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= read_accept;
      if (read_accept) begin
        rd_id <= bus.msID;
      end
    end
  end

  // Response buffer payload; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      buf_id[wr_ptr]   <= rd_id;
      buf_data[wr_ptr] <= rd_data;
    end
  end

  // Buffer pointers, occupancy and read credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= FULL_CREDITS;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({read_accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end
endmodule
